// File: rtl/screen_mem_arbiter_if.sv
// Bus bundle for screen_mem_arbiter: CPU port, video fetch port, clear control and RAM command/return.
interface screen_mem_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_gnt;
    logic              vid_rvalid;
    logic [DATA_W-1:0] vid_rdata;

    logic              clr_start;
    logic              clr_busy;
    logic              clr_done;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  vid_req, vid_addr,
        output vid_gnt, vid_rvalid, vid_rdata,
        input  clr_start,
        output clr_busy, clr_done,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output vid_req, vid_addr,
        input  vid_gnt, vid_rvalid, vid_rdata,
        output clr_start,
        input  clr_busy, clr_done,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/screen_mem_arbiter.sv
// Screen RAM arbiter: video > CPU > clear sweep, with a CPU starvation guard on long video streaks.
// Define SCREEN_CLEAR_EN to build the full-screen clear engine; otherwise clr_busy/clr_done stay 0.
module screen_mem_arbiter #(
    parameter int                ADDR_W         = 13,
    parameter int                DATA_W         = 16,
    parameter int                MAX_VID_STREAK = 4,
    parameter logic [DATA_W-1:0] CLEAR_VALUE    = 16'h0000
) (
    input logic                 clk,
    input logic                 rst_n,
    screen_mem_arbiter_if.slave bus
);
    localparam logic [3:0]        STREAK_MAX = 4'(MAX_VID_STREAK);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = {ADDR_W{1'b1}};

    logic              vid_gnt_s;
    logic              cpu_gnt_s;
    logic              clr_gnt_s;
    logic [3:0]        streak_q, streak_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]        own_q, own_d;
    logic              cpu_rvalid_q;
    logic              vid_rvalid_q;
    logic [ADDR_W-1:0] clr_addr_s;

    // Video wins unless the CPU has already waited out a full streak.
    always_comb begin
        vid_gnt_s = bus.vid_req && !(bus.cpu_req && (streak_q == STREAK_MAX));
        cpu_gnt_s = bus.cpu_req && !vid_gnt_s;
    end

    // Streak counter next state.
    always_comb begin
        streak_d = streak_q;
        if (!bus.cpu_req || cpu_gnt_s) begin
            streak_d = 4'd0;
        end else if (vid_gnt_s && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 4'd1;
        end else begin
            streak_d = streak_q;
        end
    end

    // RAM command and read-owner tag for the granted requester.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        own_d       = 2'b00;
        if (vid_gnt_s) begin
            mem_addr_d = bus.vid_addr;
            own_d      = 2'b01;
        end else if (cpu_gnt_s) begin
            mem_addr_d = bus.cpu_addr;
            mem_we_d   = bus.cpu_we;
            if (bus.cpu_we) begin
                mem_wdata_d = bus.cpu_wdata;
            end else begin
                own_d = 2'b10;
            end
        end else if (clr_gnt_s) begin
            mem_addr_d  = clr_addr_s;
            mem_we_d    = 1'b1;
            mem_wdata_d = CLEAR_VALUE;
        end else begin
            mem_addr_d = mem_addr_q;
        end
    end

    // Arbiter state, RAM command registers and the two-stage read-owner pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q     <= 4'd0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            own_q        <= 2'b00;
            cpu_rvalid_q <= 1'b0;
            vid_rvalid_q <= 1'b0;
        end else begin
            streak_q     <= streak_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            own_q        <= own_d;
            cpu_rvalid_q <= own_q[1];
            vid_rvalid_q <= own_q[0];
        end
    end

`ifdef SCREEN_CLEAR_EN
    typedef enum logic [1:0] {
        CLR_IDLE = 2'd0,
        CLR_RUN  = 2'd1,
        CLR_DONE = 2'd2
    } clr_state_e;

    clr_state_e        clr_state_q, clr_state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

    // Sweep takes only otherwise idle slots; the counter parks on the last address.
    always_comb begin
        clr_state_d = clr_state_q;
        clr_cnt_d   = clr_cnt_q;
        clr_gnt_s   = (clr_state_q == CLR_RUN) && !bus.cpu_req && !bus.vid_req;
        case (clr_state_q)
            CLR_IDLE: begin
                if (bus.clr_start) begin
                    clr_state_d = CLR_RUN;
                    clr_cnt_d   = '0;
                end else begin
                    clr_state_d = CLR_IDLE;
                end
            end
            CLR_RUN: begin
                if (clr_gnt_s && (clr_cnt_q == LAST_ADDR)) begin
                    clr_state_d = CLR_DONE;
                end else if (clr_gnt_s) begin
                    clr_cnt_d = clr_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end else begin
                    clr_state_d = CLR_RUN;
                end
            end
            CLR_DONE: clr_state_d = CLR_IDLE;
            default:  clr_state_d = CLR_IDLE;
        endcase
    end

    // Clear engine state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_state_q <= CLR_IDLE;
            clr_cnt_q   <= '0;
        end else begin
            clr_state_q <= clr_state_d;
            clr_cnt_q   <= clr_cnt_d;
        end
    end

    assign clr_addr_s   = clr_cnt_q;
    assign bus.clr_busy = (clr_state_q == CLR_RUN);
    assign bus.clr_done = (clr_state_q == CLR_DONE);
`else
    assign clr_gnt_s    = 1'b0;
    assign clr_addr_s   = '0;
    assign bus.clr_busy = 1'b0;
    assign bus.clr_done = 1'b0;
`endif

    assign bus.cpu_gnt    = cpu_gnt_s;
    assign bus.vid_gnt    = vid_gnt_s;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.vid_rvalid = vid_rvalid_q;
    assign bus.cpu_rdata  = cpu_rvalid_q ? bus.mem_rdata : '0;
    assign bus.vid_rdata  = vid_rvalid_q ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_screen_mem_arbiter.sv
// Directed bench for screen_mem_arbiter with a behavioural 8K x 16 synchronous RAM.
module tb_screen_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   pre_op = 0;
    logic [15:0] fill_val = 16'h0000;
    logic [15:0] ram [0:8191];

    always #5 clk = ~clk;

    screen_mem_arbiter_if #(.ADDR_W(13), .DATA_W(16)) bus ();

    screen_mem_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [15:0] row_word(input int k);
        return 16'h3C00 + 16'(k) * 16'd7;
    endfunction

    // RAM model: read data one cycle after the command; bench preloads go through here too.
    always @(posedge clk) begin
        bus.mem_rdata <= ram[bus.mem_addr];
        if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
        if (pre_op == 1) begin
            for (int k = 0; k < 8192; k++) ram[k] = fill_val;
        end else if (pre_op == 2) begin
            for (int k = 0; k < 32; k++) ram[k] = row_word(k);
        end else if (pre_op == 3) begin
            ram[13'h100] = 16'hC100;
            ram[13'h200] = 16'hA200;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int op, input logic [15:0] v);
        fill_val = v;
        pre_op   = op;
        cycle();
        pre_op   = 0;
    endtask

    task automatic cpu_access(input logic we, input logic [12:0] addr, input logic [15:0] wd,
                              input logic [15:0] exp_rd, input string tag);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wd;
        #1;
        check_eq({tag, "_gnt"}, 32'(bus.cpu_gnt), 32'd1);
        cycle();
        bus.cpu_req = 1'b0;
        check_eq({tag, "_mwe"}, 32'(bus.mem_we), 32'(we));
        check_eq({tag, "_maddr"}, 32'(bus.mem_addr), 32'(addr));
        if (we) begin
            check_eq({tag, "_mwdata"}, 32'(bus.mem_wdata), 32'(wd));
            cycle();
        end else begin
            check_eq({tag, "_rv_n1"}, 32'(bus.cpu_rvalid), 32'd0);
            cycle();
            check_eq({tag, "_rv_n2"}, 32'(bus.cpu_rvalid), 32'd1);
            check_eq({tag, "_rdata"}, 32'(bus.cpu_rdata), 32'(exp_rd));
            cycle();
            check_eq({tag, "_rv_n3"}, 32'(bus.cpu_rvalid), 32'd0);
        end
    endtask

    initial begin
        logic [11:0] gv, gc, rv, rc;
        int n, cnt, busy_cnt, done_cnt, vg;
        logic seen;

        rst_n         = 1'b0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 13'd0;
        bus.cpu_wdata = 16'h0000;
        bus.vid_req   = 1'b0;
        bus.vid_addr  = 13'd0;
        bus.clr_start = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_maddr", 32'(bus.mem_addr), 32'd0);
        check_eq("rst_mwe", 32'(bus.mem_we), 32'd0);
        check_eq("rst_mwdata", 32'(bus.mem_wdata), 32'd0);
        check_eq("rst_crv", 32'(bus.cpu_rvalid), 32'd0);
        check_eq("rst_vrv", 32'(bus.vid_rvalid), 32'd0);
        check_eq("rst_busy", 32'(bus.clr_busy), 32'd0);
        check_eq("rst_done", 32'(bus.clr_done), 32'd0);
        rst_n = 1'b1;
        cycle();

        // CPU write then read back.
        cpu_access(1'b1, 13'h0005, 16'h1234, 16'h0000, "cpu_wr");
        cpu_access(1'b0, 13'h0005, 16'h0000, 16'h1234, "cpu_rd");

        // Reset while a CPU read is in flight.
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 13'h0005;
        #1;
        check_eq("mid_gnt", 32'(bus.cpu_gnt), 32'd1);
        cycle();
        bus.cpu_req = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("mid_maddr", 32'(bus.mem_addr), 32'd0);
        check_eq("mid_mwdata", 32'(bus.mem_wdata), 32'd0);
        check_eq("mid_crv", 32'(bus.cpu_rvalid), 32'd0);
        cycle();
        cycle();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            seen = seen | bus.cpu_rvalid | bus.vid_rvalid;
        end
        check_eq("mid_no_rv", 32'(seen), 32'd0);

        // Both requesters held: V,V,V,V,C repeating.
        preload(3, 16'h0000);
        gv = '0; gc = '0; rv = '0; rc = '0;
        for (int i = 0; i < 12; i++) begin
            bus.cpu_req  = (i < 10);
            bus.cpu_we   = 1'b0;
            bus.cpu_addr = 13'h100;
            bus.vid_req  = (i < 10);
            bus.vid_addr = 13'h200;
            #1;
            gv[i] = bus.vid_gnt;
            gc[i] = bus.cpu_gnt;
            rv[i] = bus.vid_rvalid;
            rc[i] = bus.cpu_rvalid;
            if (i == 2) check_eq("streak_vdata", 32'(bus.vid_rdata), 32'h0000A200);
            if (i == 6) check_eq("streak_cdata", 32'(bus.cpu_rdata), 32'h0000C100);
            cycle();
        end
        check_eq("streak_vgnt", 32'(gv), 32'b000111101111);
        check_eq("streak_cgnt", 32'(gc), 32'b001000010000);
        check_eq("streak_vrv", 32'(rv), 32'b011110111100);
        check_eq("streak_crv", 32'(rc), 32'b100001000000);

        // Video-only row fetch, one address per cycle.
        preload(2, 16'h0000);
        cnt = 0;
        for (int i = 0; i < 34; i++) begin
            bus.vid_req  = (i < 32);
            bus.vid_addr = 13'(i);
            #1;
            if (i < 32 && bus.vid_gnt) cnt++;
            if (i >= 2) begin
                check_eq($sformatf("row_rv%0d", i - 2), 32'(bus.vid_rvalid), 32'd1);
                check_eq($sformatf("row_d%0d", i - 2), 32'(bus.vid_rdata), 32'(row_word(i - 2)));
            end
            cycle();
        end
        check_eq("row_grants", 32'(cnt), 32'd32);

`ifdef SCREEN_CLEAR_EN
        // Idle clear sweep over a framebuffer of all ones.
        preload(1, 16'hFFFF);
        bus.clr_start = 1'b1;
        cycle();
        bus.clr_start = 1'b0;
        busy_cnt = 0; done_cnt = 0; n = 0;
        while (n < 9000 && done_cnt == 0) begin
            if (bus.clr_busy) busy_cnt++;
            if (bus.clr_done) done_cnt++;
            n++;
            cycle();
        end
        check_eq("clr_timeout", 32'(n < 9000), 32'd1);
        repeat (3) begin
            if (bus.clr_done) done_cnt++;
            cycle();
        end
        check_eq("clr_busy_cycles", 32'(busy_cnt), 32'd8192);
        check_eq("clr_done_pulses", 32'(done_cnt), 32'd1);
        cpu_access(1'b0, 13'd0, 16'h0000, 16'h0000, "clr_rd0");
        cpu_access(1'b0, 13'd4095, 16'h0000, 16'h0000, "clr_rd4095");
        cpu_access(1'b0, 13'd8191, 16'h0000, 16'h0000, "clr_rd8191");

        // Sweep sharing slots with video on alternate cycles; a second start is ignored.
        preload(1, 16'hFFFF);
        bus.clr_start = 1'b1;
        cycle();
        busy_cnt = 0; done_cnt = 0; vg = 0; n = 0;
        while (n < 20000 && done_cnt == 0) begin
            bus.clr_start = (n == 100);
            bus.vid_req   = (n % 2 == 0);
            bus.vid_addr  = 13'(n);
            #1;
            if (bus.clr_busy) begin
                busy_cnt++;
                if (bus.vid_gnt) vg++;
            end
            if (bus.clr_done) done_cnt++;
            n++;
            cycle();
        end
        bus.vid_req   = 1'b0;
        bus.clr_start = 1'b0;
        check_eq("clr2_timeout", 32'(n < 20000), 32'd1);
        repeat (3) begin
            if (bus.clr_done) done_cnt++;
            cycle();
        end
        check_eq("clr2_busy_vs_vid", 32'(busy_cnt), 32'(8192 + vg));
        check_eq("clr2_vid_grants", 32'(vg), 32'd8192);
        check_eq("clr2_done_pulses", 32'(done_cnt), 32'd1);
        cpu_access(1'b0, 13'd8191, 16'h0000, 16'h0000, "clr2_rd8191");
`else
        // Without the clear engine a start pulse must do nothing.
        bus.clr_start = 1'b1;
        cycle();
        bus.clr_start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            seen = seen | bus.clr_busy | bus.clr_done | bus.mem_we;
            cycle();
        end
        check_eq("noclr_idle", 32'(seen), 32'd0);
        busy_cnt = 0; done_cnt = 0; vg = 0; n = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
